// File: rtl/decoder_scan_generic.sv
// Registered N-to-2**N line decoder with one-hot/thermometer output and an optional
// auto-advancing scan mode that dwells DWELL enabled cycles on each line.
module decoder_scan_generic #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic            load,
  input  logic [N-1:0]    w,
  input  logic            thermo,
  output logic [0:2**N-1] y,
  output logic [N-1:0]    idx,
  output logic            wrap
);

  localparam int unsigned Lines = 2 ** N;
  localparam int unsigned CntW  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DWELL - 1);
  localparam logic [N-1:0]    IdxMax = {N{1'b1}};

  logic [N-1:0]     idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [0:Lines-1] y_q, y_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    y_d    = '0;
    if (en) begin
      if (load) begin
        idx_d = w;
        cnt_d = '0;
      end else if (!mode) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        cnt_d  = '0;
        idx_d  = idx_q + N'(1);
        wrap_d = (idx_q == IdxMax);
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
      // Decode the index being written this edge so y has no extra latency.
      for (int unsigned i = 0; i < Lines; i++) begin
        y_d[i] = thermo ? (N'(i) <= idx_d) : (N'(i) == idx_d);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      y_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
